axi_mem_arbiter: RTL and testbench
==================================

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 The block SHALL have exactly one parameter: RR_ENA, default 1; 1 selects round-robin grant, 0 selects fixed priority m0 read > m1 read > m1 write.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 m0_axi_araddr/arprot/arvalid  in  32/3/1  instruction-fetch read address; m0_axi_arready  out  1.
REQ-005 m0_axi_rdata/rresp/rvalid  out  32/2/1  instruction-fetch read data; m0_axi_rready  in  1.
REQ-006 m1_axi_araddr/arprot/arvalid  in  32/3/1  data read address; m1_axi_arready  out  1.
REQ-007 m1_axi_rdata/rresp/rvalid  out  32/2/1  data read data; m1_axi_rready  in  1.
REQ-008 m1_axi_awaddr/awprot/awvalid  in  32/3/1; m1_axi_wdata/wstrb/wvalid  in  32/4/1; m1_axi_awready, m1_axi_wready  out  1 each.
REQ-009 m1_axi_bresp/bvalid  out  2/1; m1_axi_bready  in  1.
REQ-010 s_axi_* (aw, w, b, ar, r channels)  master side toward the single-port memory, widths as above, opposite directions.
REQ-011 grant  out  2  current owner: 0 none, 1 m0 read, 2 m1 read, 3 m1 write.

Function
REQ-012 The block SHALL serve one transaction at a time on s_axi; no read and write SHALL ever overlap.
REQ-013 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-014 IDLE: requests are m0 arvalid, m1 arvalid, m1 (awvalid AND wvalid); the winner SHALL be registered and the FSM SHALL move to RD_ADDR or WR_REQ on the next edge; no request keeps IDLE.
REQ-015 Round-robin order m0R -> m1R -> m1W; the requester after the last completed grant SHALL have highest priority; after reset, m0R SHALL have highest priority.
REQ-016 RD_ADDR: s_arvalid=1, s_araddr/arprot SHALL be muxed from the granted master; the granted master's arready SHALL equal s_arready; on s_arvalid AND s_arready the FSM SHALL go to RD_DATA.
REQ-017 RD_DATA: s_rready SHALL equal the granted master's rready; that master's rvalid/rdata/rresp SHALL equal s_r*; on s_rvalid AND s_rready the FSM SHALL go to IDLE and update the round-robin pointer.
REQ-018 WR_REQ: s_awvalid and s_wvalid SHALL be asserted independently, each dropped after its own handshake, tracked by aw_done/w_done flags; when both are done the FSM SHALL go to WR_RESP.
REQ-019 Simultaneous AW and W handshake in one cycle SHALL move directly to WR_RESP.
REQ-020 WR_RESP: s_bready=m1_bready, m1_bvalid/bresp=s_b*; on the B handshake the FSM SHALL go to IDLE and update the pointer.
REQ-021 All ready/valid outputs to a non-granted master, and all s_axi valid/ready outputs outside their owning states, SHALL be 0.
REQ-022 rresp/bresp SHALL pass through unmodified, SLVERR/DECERR included.
REQ-023 Minimum latency: request in IDLE at cycle n -> s_*valid at cycle n+1; the minimum read is 3 cycles from arvalid to IDLE.
REQ-024 A master dropping arvalid before grant SHALL NOT be granted; once in RD_ADDR the FSM SHALL wait for the handshake.

Reset
REQ-025 reset=0 at any edge SHALL force IDLE, grant=0, aw_done=w_done=0, pointer to m0R, all valid/ready outputs 0, regardless of the transaction in flight.
REQ-026 Data outputs (s_araddr, rdata, etc.) are don't-care while their valid is 0.

Verification
REQ-027 m0 and m1 arvalid together after reset, s_arready=1, s_rvalid one cycle later -> m0 served first (grant=1), then m1 (grant=2); m1_arready stays 0 until its grant.
REQ-028 m1 write with s_awready one cycle before s_wready -> s_awvalid drops after the AW handshake, s_wvalid held, WR_RESP entered after W; bresp=2'b10 reaches m1 unchanged.
REQ-029 All three requesters continuously active, RR_ENA=1 -> grant sequence 1,2,3,1,2,3; RR_ENA=0 -> grant stays 1 every transaction.
REQ-030 reset=0 asserted in RD_DATA with s_rvalid=0 -> next cycle grant=0, s_rready=0, m0_rvalid=0; the first request after release is accepted normally.
REQ-031 s_rvalid=1 held while m0_rready=0 for 4 cycles -> FSM stays RD_DATA, s_rready=0, data stable; completes on the first cycle m0_rready=1.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Arbitrates an instruction-fetch read port and a data read/write port onto one
// single-ported AXI-Lite memory, serving exactly one transaction at a time.
module axi_mem_arbiter #(
  parameter bit RR_ENA = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_axi_araddr,
  input  logic [2:0]  m0_axi_arprot,
  input  logic        m0_axi_arvalid,
  output logic        m0_axi_arready,
  output logic [31:0] m0_axi_rdata,
  output logic [1:0]  m0_axi_rresp,
  output logic        m0_axi_rvalid,
  input  logic        m0_axi_rready,
  input  logic [31:0] m1_axi_araddr,
  input  logic [2:0]  m1_axi_arprot,
  input  logic        m1_axi_arvalid,
  output logic        m1_axi_arready,
  output logic [31:0] m1_axi_rdata,
  output logic [1:0]  m1_axi_rresp,
  output logic        m1_axi_rvalid,
  input  logic        m1_axi_rready,
  input  logic [31:0] m1_axi_awaddr,
  input  logic [2:0]  m1_axi_awprot,
  input  logic        m1_axi_awvalid,
  output logic        m1_axi_awready,
  input  logic [31:0] m1_axi_wdata,
  input  logic [3:0]  m1_axi_wstrb,
  input  logic        m1_axi_wvalid,
  output logic        m1_axi_wready,
  output logic [1:0]  m1_axi_bresp,
  output logic        m1_axi_bvalid,
  input  logic        m1_axi_bready,
  output logic [31:0] s_axi_awaddr,
  output logic [2:0]  s_axi_awprot,
  output logic        s_axi_awvalid,
  input  logic        s_axi_awready,
  output logic [31:0] s_axi_wdata,
  output logic [3:0]  s_axi_wstrb,
  output logic        s_axi_wvalid,
  input  logic        s_axi_wready,
  input  logic [1:0]  s_axi_bresp,
  input  logic        s_axi_bvalid,
  output logic        s_axi_bready,
  output logic [31:0] s_axi_araddr,
  output logic [2:0]  s_axi_arprot,
  output logic        s_axi_arvalid,
  input  logic        s_axi_arready,
  input  logic [31:0] s_axi_rdata,
  input  logic [1:0]  s_axi_rresp,
  input  logic        s_axi_rvalid,
  output logic        s_axi_rready,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [2:0] req;
  logic [2:0] sum;
  logic [1:0] idx;
  logic [1:0] winner;
  logic       rd_m0;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Requester index 0 = m0 read, 1 = m1 read, 2 = m1 write; grant code is index + 1.
  assign req = {m1_axi_awvalid & m1_axi_wvalid, m1_axi_arvalid, m0_axi_arvalid};

  always_comb begin
    winner = 2'd0;
    sum    = 3'd0;
    idx    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = RR_ENA ? ({1'b0, ptr_q} + 3'(k)) : 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (winner == 2'd0 && req[idx]) winner = idx + 2'd1;
    end
  end

  assign rd_m0 = (grant_q == 2'd1);
  assign ar_hs = (state_q == RD_ADDR) && s_axi_arready;
  assign r_hs  = (state_q == RD_DATA) && s_axi_rvalid && s_axi_rready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = (state_q == WR_RESP) && s_axi_bvalid && m1_axi_bready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (winner != 2'd0) begin
          grant_d = winner;
          state_d = (winner == 2'd3) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: begin
        // The requester after a completed read is the one with the next grant code.
        if (r_hs) begin
          state_d = IDLE;
          grant_d = 2'd0;
          ptr_d   = grant_q;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = 2'd0;
          ptr_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      ptr_q     <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant = grant_q;

  assign s_axi_arvalid  = (state_q == RD_ADDR);
  assign s_axi_araddr   = rd_m0 ? m0_axi_araddr : m1_axi_araddr;
  assign s_axi_arprot   = rd_m0 ? m0_axi_arprot : m1_axi_arprot;
  assign m0_axi_arready = s_axi_arvalid && rd_m0 && s_axi_arready;
  assign m1_axi_arready = s_axi_arvalid && (grant_q == 2'd2) && s_axi_arready;

  assign s_axi_rready  = (state_q == RD_DATA) && (rd_m0 ? m0_axi_rready : m1_axi_rready);
  assign m0_axi_rvalid = (state_q == RD_DATA) && rd_m0 && s_axi_rvalid;
  assign m1_axi_rvalid = (state_q == RD_DATA) && (grant_q == 2'd2) && s_axi_rvalid;
  assign m0_axi_rdata  = s_axi_rdata;
  assign m0_axi_rresp  = s_axi_rresp;
  assign m1_axi_rdata  = s_axi_rdata;
  assign m1_axi_rresp  = s_axi_rresp;

  // AW and W are issued independently; each drops once its own handshake is done.
  assign s_axi_awvalid  = (state_q == WR_REQ) && !aw_done_q;
  assign s_axi_wvalid   = (state_q == WR_REQ) && !w_done_q;
  assign s_axi_awaddr   = m1_axi_awaddr;
  assign s_axi_awprot   = m1_axi_awprot;
  assign s_axi_wdata    = m1_axi_wdata;
  assign s_axi_wstrb    = m1_axi_wstrb;
  assign m1_axi_awready = s_axi_awvalid && s_axi_awready;
  assign m1_axi_wready  = s_axi_wvalid && s_axi_wready;

  assign s_axi_bready  = (state_q == WR_RESP) && m1_axi_bready;
  assign m1_axi_bvalid = (state_q == WR_RESP) && s_axi_bvalid;
  assign m1_axi_bresp  = s_axi_bresp;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a transaction-level model checks every cycle,
// plus literal expectations for the round-robin, fixed-priority, reset and stall cases.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_axi_araddr = '0, m1_axi_araddr = '0, m1_axi_awaddr = '0, m1_axi_wdata = '0;
  logic [2:0]  m0_axi_arprot = '0, m1_axi_arprot = '0, m1_axi_awprot = '0;
  logic [3:0]  m1_axi_wstrb = '0;
  logic        m0_axi_arvalid = 0, m0_axi_rready = 0, m1_axi_arvalid = 0, m1_axi_rready = 0;
  logic        m1_axi_awvalid = 0, m1_axi_wvalid = 0, m1_axi_bready = 0;
  logic        s_axi_awready = 0, s_axi_wready = 0, s_axi_bvalid = 0, s_axi_arready = 0, s_axi_rvalid = 0;
  logic [1:0]  s_axi_bresp = '0, s_axi_rresp = '0;
  logic [31:0] s_axi_rdata = '0;

  logic        m0_axi_arready, m0_axi_rvalid, m1_axi_arready, m1_axi_rvalid;
  logic [31:0] m0_axi_rdata, m1_axi_rdata;
  logic [1:0]  m0_axi_rresp, m1_axi_rresp, m1_axi_bresp, grant;
  logic        m1_axi_awready, m1_axi_wready, m1_axi_bvalid;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;

  logic        f_m0_arready, f_m0_rvalid, f_m1_arready, f_m1_rvalid;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_m1_bresp, f_grant;
  logic        f_m1_awready, f_m1_wready, f_m1_bvalid;
  logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
  logic [2:0]  f_s_awprot, f_s_arprot;
  logic [3:0]  f_s_wstrb;
  logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.RR_ENA(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid),
    .m0_axi_arready(m0_axi_arready), .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid),
    .m1_axi_arready(m1_axi_arready), .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp),
    .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid),
    .m1_axi_awready(m1_axi_awready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_bresp(m1_axi_bresp),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .grant(grant)
  );

  axi_mem_arbiter #(.RR_ENA(1'b0)) f_dut (
    .clk(clk), .reset(reset),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid),
    .m0_axi_arready(f_m0_arready), .m0_axi_rdata(f_m0_rdata), .m0_axi_rresp(f_m0_rresp),
    .m0_axi_rvalid(f_m0_rvalid), .m0_axi_rready(m0_axi_rready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid),
    .m1_axi_arready(f_m1_arready), .m1_axi_rdata(f_m1_rdata), .m1_axi_rresp(f_m1_rresp),
    .m1_axi_rvalid(f_m1_rvalid), .m1_axi_rready(m1_axi_rready),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid),
    .m1_axi_awready(f_m1_awready), .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(f_m1_wready), .m1_axi_bresp(f_m1_bresp),
    .m1_axi_bvalid(f_m1_bvalid), .m1_axi_bready(m1_axi_bready),
    .s_axi_awaddr(f_s_awaddr), .s_axi_awprot(f_s_awprot), .s_axi_awvalid(f_s_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(f_s_wdata), .s_axi_wstrb(f_s_wstrb),
    .s_axi_wvalid(f_s_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(f_s_bready),
    .s_axi_araddr(f_s_araddr), .s_axi_arprot(f_s_arprot), .s_axi_arvalid(f_s_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(f_s_rready), .grant(f_grant)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;
  bit rec_en = 0;
  int rr_seq[$];
  int fx_seq[$];
  logic [1:0] prev_rr = '0, prev_fx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the owner of the memory and which beats of its transaction are still outstanding.
  int m_owner = 0;
  int m_ptr = 0;
  bit m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0;

  function automatic int pick(input int ptr);
    bit [2:0] r;
    int id;
    r = {m1_axi_awvalid & m1_axi_wvalid, m1_axi_arvalid, m0_axi_arvalid};
    for (int k = 0; k < 3; k++) begin
      id = (ptr + k) % 3;
      if (r[id]) return id + 1;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_owner <= 0; m_ptr <= 0;
      m_ar <= 0; m_r <= 0; m_aw <= 0; m_w <= 0; m_b <= 0;
    end else if (m_owner == 0) begin
      if (pick(m_ptr) != 0) begin
        m_owner <= pick(m_ptr);
        if (pick(m_ptr) == 3) begin m_aw <= 1; m_w <= 1; end
        else m_ar <= 1;
      end
    end else if (m_owner < 3) begin
      if (m_ar && s_axi_arready) begin
        m_ar <= 0; m_r <= 1;
      end else if (m_r && s_axi_rvalid && (m_owner == 1 ? m0_axi_rready : m1_axi_rready)) begin
        m_r <= 0; m_owner <= 0; m_ptr <= m_owner % 3;
      end
    end else begin
      if (m_aw && s_axi_awready) m_aw <= 0;
      if (m_w && s_axi_wready) m_w <= 0;
      if ((m_aw || m_w) && !(m_aw && !s_axi_awready) && !(m_w && !s_axi_wready)) m_b <= 1;
      if (m_b && s_axi_bvalid && m1_axi_bready) begin
        m_b <= 0; m_owner <= 0; m_ptr <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", 32'(grant), 32'(m_owner));
      check("s_arvalid", 32'(s_axi_arvalid), 32'(m_ar));
      if (m_ar) begin
        check("s_araddr", s_axi_araddr, m_owner == 1 ? m0_axi_araddr : m1_axi_araddr);
        check("s_arprot", 32'(s_axi_arprot), 32'(m_owner == 1 ? m0_axi_arprot : m1_axi_arprot));
      end
      check("m0_arready", 32'(m0_axi_arready), 32'(m_ar && m_owner == 1 && s_axi_arready));
      check("m1_arready", 32'(m1_axi_arready), 32'(m_ar && m_owner == 2 && s_axi_arready));
      check("s_rready", 32'(s_axi_rready),
            32'(m_r && (m_owner == 1 ? m0_axi_rready : m1_axi_rready)));
      check("m0_rvalid", 32'(m0_axi_rvalid), 32'(m_r && m_owner == 1 && s_axi_rvalid));
      check("m1_rvalid", 32'(m1_axi_rvalid), 32'(m_r && m_owner == 2 && s_axi_rvalid));
      if (m_r && m_owner == 1 && s_axi_rvalid) begin
        check("m0_rdata", m0_axi_rdata, s_axi_rdata);
        check("m0_rresp", 32'(m0_axi_rresp), 32'(s_axi_rresp));
      end
      if (m_r && m_owner == 2 && s_axi_rvalid) begin
        check("m1_rdata", m1_axi_rdata, s_axi_rdata);
        check("m1_rresp", 32'(m1_axi_rresp), 32'(s_axi_rresp));
      end
      check("s_awvalid", 32'(s_axi_awvalid), 32'(m_aw));
      check("s_wvalid", 32'(s_axi_wvalid), 32'(m_w));
      if (m_aw) check("s_awaddr", s_axi_awaddr, m1_axi_awaddr);
      if (m_w) check("s_wdata", s_axi_wdata, m1_axi_wdata);
      if (m_w) check("s_wstrb", 32'(s_axi_wstrb), 32'(m1_axi_wstrb));
      check("m1_awready", 32'(m1_axi_awready), 32'(m_aw && s_axi_awready));
      check("m1_wready", 32'(m1_axi_wready), 32'(m_w && s_axi_wready));
      check("s_bready", 32'(s_axi_bready), 32'(m_b && m1_axi_bready));
      check("m1_bvalid", 32'(m1_axi_bvalid), 32'(m_b && s_axi_bvalid));
      if (m_b && s_axi_bvalid) check("m1_bresp", 32'(m1_axi_bresp), 32'(s_axi_bresp));
      check("no_overlap", 32'((s_axi_arvalid | s_axi_rready) & (s_axi_awvalid | s_axi_wvalid | s_axi_bready)), 32'd0);
    end
    if (rec_en) begin
      if (grant != 2'd0 && prev_rr == 2'd0) rr_seq.push_back(int'(grant));
      if (f_grant != 2'd0 && prev_fx == 2'd0) fx_seq.push_back(int'(f_grant));
    end
    prev_rr <= grant;
    prev_fx <= f_grant;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_axi_arvalid = 0; m0_axi_rready = 0; m1_axi_arvalid = 0; m1_axi_rready = 0;
    m1_axi_awvalid = 0; m1_axi_wvalid = 0; m1_axi_bready = 0;
    s_axi_awready = 0; s_axi_wready = 0; s_axi_bvalid = 0; s_axi_arready = 0; s_axi_rvalid = 0;
    s_axi_bresp = 2'b00; s_axi_rresp = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[6]);
    for (int i = 0; i < 6; i++)
      check(name, 32'(i < got.size() ? got[i] : 0), 32'(exp[i]));
  endtask

  initial begin
    int exp_rr[6];
    int exp_fx[6];
    exp_rr = '{1, 2, 3, 1, 2, 3};
    exp_fx = '{1, 1, 1, 1, 1, 1};
    m0_axi_araddr = 32'h0000_1000; m0_axi_arprot = 3'b100;
    m1_axi_araddr = 32'h2000_0040; m1_axi_arprot = 3'b001;
    m1_axi_awaddr = 32'h2000_0080; m1_axi_awprot = 3'b010;
    m1_axi_wdata = 32'hDEAD_BEEF;  m1_axi_wstrb = 4'b1011;
    s_axi_rdata = 32'h1234_5678;

    do_reset();
    chk_en = 1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_arvalid", 32'(s_axi_arvalid), 32'd0);

    // m0 and m1 read together: m0 first, then m1
    m0_axi_arvalid = 1; m1_axi_arvalid = 1; m0_axi_rready = 1; m1_axi_rready = 1;
    s_axi_arready = 1; s_axi_rvalid = 1;
    rr_seq.delete(); fx_seq.delete(); rec_en = 1;
    repeat (7) step();
    rec_en = 0;
    check("dual_read_first", 32'(rr_seq.size() > 0 ? rr_seq[0] : 0), 32'd1);
    check("dual_read_second", 32'(rr_seq.size() > 1 ? rr_seq[1] : 0), 32'd2);

    // write with AW accepted one cycle before W, SLVERR response
    do_reset();
    m1_axi_awvalid = 1; m1_axi_wvalid = 1; s_axi_awready = 1;
    step();
    check("wr_grant", 32'(grant), 32'd3);
    check("wr_both_valid", 32'({s_axi_awvalid, s_axi_wvalid}), 32'b11);
    step();
    m1_axi_awvalid = 0; s_axi_wready = 1;
    #1;
    check("wr_aw_dropped", 32'({s_axi_awvalid, s_axi_wvalid}), 32'b01);
    step();
    m1_axi_wvalid = 0; s_axi_bvalid = 1; s_axi_bresp = 2'b10; m1_axi_bready = 1;
    #1;
    check("wr_resp_bvalid", 32'(m1_axi_bvalid), 32'd1);
    check("wr_resp_bresp", 32'(m1_axi_bresp), 32'd2);
    step();
    s_axi_bvalid = 0;
    #1;
    check("wr_done_grant", 32'(grant), 32'd0);

    // reset during RD_DATA, then a normal m1 read with DECERR
    do_reset();
    m0_axi_arvalid = 1; m0_axi_rready = 1; s_axi_arready = 1;
    step();
    step();
    m0_axi_arvalid = 0;
    #1;
    check("rd_data_grant", 32'(grant), 32'd1);
    reset = 0;
    step();
    s_axi_rvalid = 1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_s_rready", 32'(s_axi_rready), 32'd0);
    check("mid_rst_m0_rvalid", 32'(m0_axi_rvalid), 32'd0);
    reset = 1; s_axi_rvalid = 0; m1_axi_arvalid = 1; m1_axi_rready = 1;
    step();
    check("post_rst_grant", 32'(grant), 32'd2);
    m1_axi_arvalid = 0;
    step();
    s_axi_rvalid = 1; s_axi_rresp = 2'b11; s_axi_rdata = 32'hA5A5_0003;
    #1;
    check("post_rst_rresp", 32'(m1_axi_rresp), 32'd3);
    step();
    s_axi_rvalid = 0;
    #1;
    check("post_rst_idle", 32'(grant), 32'd0);

    // m0 stalls read data for four cycles
    do_reset();
    m0_axi_arvalid = 1; s_axi_arready = 1; s_axi_rvalid = 1;
    s_axi_rdata = 32'hCAFE_0031; s_axi_rresp = 2'b10;
    step();
    m0_axi_arvalid = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("stall_s_rready", 32'(s_axi_rready), 32'd0);
      check("stall_m0_rvalid", 32'(m0_axi_rvalid), 32'd1);
      check("stall_m0_rdata", m0_axi_rdata, 32'hCAFE_0031);
      step();
    end
    check("stall_rresp", 32'(m0_axi_rresp), 32'd2);
    m0_axi_rready = 1;
    #1;
    check("stall_release", 32'(s_axi_rready), 32'd1);
    step();
    check("stall_done", 32'(grant), 32'd0);

    // all three requesters busy: RR rotates, fixed priority always picks m0
    do_reset();
    m0_axi_arvalid = 1; m1_axi_arvalid = 1; m1_axi_awvalid = 1; m1_axi_wvalid = 1;
    m0_axi_rready = 1; m1_axi_rready = 1; m1_axi_bready = 1;
    s_axi_arready = 1; s_axi_rvalid = 1; s_axi_awready = 1; s_axi_wready = 1; s_axi_bvalid = 1;
    rr_seq.delete(); fx_seq.delete(); rec_en = 1;
    repeat (30) step();
    rec_en = 0;
    check_seq("rr_sequence", rr_seq, exp_rr);
    check_seq("fixed_sequence", fx_seq, exp_fx);

    clear_inputs();
    repeat (5) step();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
